// File: rtl/mem_dualport_param.sv
// mem_dualport_param: two-port synchronous word memory with registered reads,
// write-first forwarding between ports, port 1 priority on colliding writes,
// and a sticky out-of-range address flag.
// Optional macro MEM_INIT_CLEAR_EN: zero the whole array after reset with a
// one-word-per-cycle sweep before accepting requests. When undefined, reset
// goes straight to RUN and memory contents survive reset.
//
// state | meaning
// ------+--------------------------------------------------------------
// INIT  | clear sweep in progress, requests refused (ready=0)
// RUN   | normal operation, requests accepted while rst is low
module mem_dualport_param #(
  parameter int WORD_SIZE  = 64,
  parameter int ADDR_WIDTH = 7,
  parameter int DEPTH      = 110
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ready,
  input  logic [ADDR_WIDTH-1:0] add1,
  input  logic [ADDR_WIDTH-1:0] add2,
  input  logic [WORD_SIZE-1:0]  dataIn1,
  input  logic [WORD_SIZE-1:0]  dataIn2,
  input  logic                  en1,
  input  logic                  en2,
  input  logic                  write1,
  input  logic                  write2,
  output logic [WORD_SIZE-1:0]  dataOut1,
  output logic [WORD_SIZE-1:0]  dataOut2,
  output logic                  valid1,
  output logic                  valid2,
  output logic                  addrErr
);

  // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic {INIT, RUN} state_t;

  state_t state, state_next;

  logic [WORD_SIZE-1:0] mem [DEPTH];

  logic acc1, acc2, wr1, wr2, rd1, rd2, ok1, ok2;
  logic [WORD_SIZE-1:0] rd_data1, rd_data2;

  // Requests count only in RUN with reset released.
  assign ready = (state == RUN) && !rst;
  assign acc1  = en1 && ready;
  assign acc2  = en2 && ready;
  assign wr1   = acc1 && write1;
  assign wr2   = acc2 && write2;
  assign rd1   = acc1 && !write1;
  assign rd2   = acc2 && !write2;
  assign ok1   = ({1'b0, add1} < DEPTH_W);
  assign ok2   = ({1'b0, add2} < DEPTH_W);

`ifdef MEM_INIT_CLEAR_EN
  localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] clr_cnt;

  // Clear sweep address: restarts at 0 on every reset, advances during INIT.
  always_ff @(posedge clk) begin
    if (rst)
      clr_cnt <= '0;
    else if (state == INIT)
      clr_cnt <= clr_cnt + 1'b1;
  end

  // Next state: leave INIT on the cycle the last word is cleared.
  always_comb begin
    state_next = state;
    case (state)
      INIT:    if (clr_cnt == CLR_LAST) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = INIT;
    endcase
  end

  // State register; reset always restarts the sweep.
  always_ff @(posedge clk) begin
    if (rst)
      state <= INIT;
    else
      state <= state_next;
  end
`else
  // Next state: without the sweep there is nothing to wait for.
  always_comb begin
    state_next = RUN;
  end

  // State register; reset lands directly in RUN.
  always_ff @(posedge clk) begin
    if (rst)
      state <= RUN;
    else
      state <= state_next;
  end
`endif

  // Read mux: out-of-range reads return zero; a same-cycle write from the
  // other port to the same word is forwarded.
  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    if (ok1) begin
      if (wr2 && add2 == add1) rd_data1 = dataIn2;
      else                     rd_data1 = mem[add1];
    end
    if (ok2) begin
      if (wr1 && add1 == add2) rd_data2 = dataIn1;
      else                     rd_data2 = mem[add2];
    end
  end

  // Storage array; port 1 is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
`ifdef MEM_INIT_CLEAR_EN
    if (!rst && state == INIT)
      mem[clr_cnt] <= '0;
`endif
    if (wr2 && ok2)
      mem[add2] <= dataIn2;
    if (wr1 && ok1)
      mem[add1] <= dataIn1;
  end

  // Registered read outputs, valid pulses and the sticky address error.
  always_ff @(posedge clk) begin
    if (rst) begin
      dataOut1 <= '0;
      dataOut2 <= '0;
      valid1   <= 1'b0;
      valid2   <= 1'b0;
      addrErr  <= 1'b0;
    end else begin
      valid1 <= rd1;
      valid2 <= rd2;
      if (rd1) dataOut1 <= rd_data1;
      if (rd2) dataOut2 <= rd_data2;
      if ((acc1 && !ok1) || (acc2 && !ok2))
        addrErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_dualport_param.sv
// Directed bench for mem_dualport_param (WORD_SIZE=64, ADDR_WIDTH=7, DEPTH=110).
module tb_mem_dualport_param;

  localparam int W  = 64;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          ready;
  logic [AW-1:0] add1, add2;
  logic [W-1:0]  dataIn1, dataIn2;
  logic          en1, en2, write1, write2;
  logic [W-1:0]  dataOut1, dataOut2;
  logic          valid1, valid2, addrErr;

  int n_total = 0;
  int n_pass  = 0;

  mem_dualport_param #(.WORD_SIZE(W), .ADDR_WIDTH(AW), .DEPTH(110)) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .add1(add1), .add2(add2), .dataIn1(dataIn1), .dataIn2(dataIn2),
    .en1(en1), .en2(en2), .write1(write1), .write2(write2),
    .dataOut1(dataOut1), .dataOut2(dataOut2),
    .valid1(valid1), .valid2(valid2), .addrErr(addrErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          en1, w1;
    logic [AW-1:0] a1;
    logic [W-1:0]  d1;
    logic          en2, w2;
    logic [AW-1:0] a2;
    logic [W-1:0]  d2;
    logic          xv1;
    logic [W-1:0]  xd1;
    logic          xv2;
    logic [W-1:0]  xd2;
    logic          xerr;
  } vec_t;

  vec_t vecs [14];

  localparam logic [W-1:0] PAT = 64'h0000_0B00_0030_0003;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en1 = 0; en2 = 0; write1 = 0; write2 = 0;
    add1 = '0; add2 = '0; dataIn1 = '0; dataIn2 = '0;
  endtask

  // Counts cycles with ready low after rst release; bounded.
  task automatic count_ready_low(output int n);
    n = 0;
    while (!ready && n < 300) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    idle();
    rst = 1'b1;
    step();
    step();
    // Requests during reset must be ignored.
    en1 = 1; write1 = 1; add1 = 7'd3; dataIn1 = 64'hFFFF;
    step();
    chk("rst_ready", {63'b0, ready}, 64'd0);
    chk("rst_valid", {62'b0, valid1, valid2}, 64'd0);
    chk("rst_dout1", dataOut1, 64'd0);
    chk("rst_dout2", dataOut2, 64'd0);
    chk("rst_err", {63'b0, addrErr}, 64'd0);
    idle();
    rst = 1'b0;
    #1;
`ifdef MEM_INIT_CLEAR_EN
    count_ready_low(n);
    chk("init_ready_low_cycles", 64'(n), 64'd110);
    for (int a = 0; a < 110; a++) begin
      en1 = 1; write1 = 0; add1 = AW'(a);
      step();
      chk("init_zero", dataOut1, 64'd0);
    end
    idle();
`else
    chk("ready_after_rst", {63'b0, ready}, 64'd1);
`endif

    //           en1 w1 a1     d1             en2 w2 a2     d2          xv1 xd1      xv2 xd2      xerr
    vecs[0]  = '{1, 1, 7'd10,  PAT,           0, 0, 7'd0,   64'h0,      0, 64'h0,    0, 64'h0,    0};
    vecs[1]  = '{0, 0, 7'd0,   64'h0,         1, 0, 7'd10,  64'h0,      0, 64'h0,    1, PAT,      0};
    vecs[2]  = '{1, 1, 7'd5,   64'hAAAA,      1, 1, 7'd5,   64'h5555,   0, 64'h0,    0, PAT,      0};
    vecs[3]  = '{1, 0, 7'd5,   64'h0,         0, 0, 7'd0,   64'h0,      1, 64'hAAAA, 0, PAT,      0};
    vecs[4]  = '{1, 1, 7'd7,   64'h1234,      1, 0, 7'd7,   64'h0,      0, 64'hAAAA, 1, 64'h1234, 0};
    vecs[5]  = '{1, 0, 7'd20,  64'h0,         1, 1, 7'd20,  64'hBEEF,   1, 64'hBEEF, 0, 64'h1234, 0};
    vecs[6]  = '{0, 1, 7'd5,   64'hFFFF,      1, 0, 7'd5,   64'h0,      0, 64'hBEEF, 1, 64'hAAAA, 0};
    vecs[7]  = '{1, 0, 7'd5,   64'h0,         0, 0, 7'd0,   64'h0,      1, 64'hAAAA, 0, 64'hAAAA, 0};
    vecs[8]  = '{1, 1, 7'd109, 64'h109,       1, 1, 7'd0,   64'h77,     0, 64'hAAAA, 0, 64'hAAAA, 0};
    vecs[9]  = '{1, 0, 7'd109, 64'h0,         1, 0, 7'd0,   64'h0,      1, 64'h109,  1, 64'h77,   0};
    vecs[10] = '{0, 0, 7'd0,   64'h0,         1, 0, 7'd120, 64'h0,      0, 64'h109,  1, 64'h0,    1};
    vecs[11] = '{1, 0, 7'd7,   64'h0,         0, 0, 7'd0,   64'h0,      1, 64'h1234, 0, 64'h0,    1};
    vecs[12] = '{1, 1, 7'd110, 64'hDEAD,      1, 0, 7'd109, 64'h0,      0, 64'h1234, 1, 64'h109,  1};
    vecs[13] = '{0, 0, 7'd0,   64'h0,         0, 0, 7'd0,   64'h0,      0, 64'h1234, 0, 64'h109,  1};

    for (int i = 0; i < 14; i++) begin
      en1 = vecs[i].en1; write1 = vecs[i].w1; add1 = vecs[i].a1; dataIn1 = vecs[i].d1;
      en2 = vecs[i].en2; write2 = vecs[i].w2; add2 = vecs[i].a2; dataIn2 = vecs[i].d2;
      step();
      chk($sformatf("v%0d_valid1", i), {63'b0, valid1}, {63'b0, vecs[i].xv1});
      chk($sformatf("v%0d_dout1", i), dataOut1, vecs[i].xd1);
      chk($sformatf("v%0d_valid2", i), {63'b0, valid2}, {63'b0, vecs[i].xv2});
      chk($sformatf("v%0d_dout2", i), dataOut2, vecs[i].xd2);
      chk($sformatf("v%0d_err", i), {63'b0, addrErr}, {63'b0, vecs[i].xerr});
    end
    idle();

    // addrErr stays set across idle cycles until reset.
    step();
    step();
    chk("err_sticky", {63'b0, addrErr}, 64'd1);

    // Mid-run reset with a write attempt to address 10 held during reset.
    rst = 1'b1;
    en1 = 1; write1 = 1; add1 = 7'd10; dataIn1 = 64'h5A5A;
    #1;
    chk("midrst_ready", {63'b0, ready}, 64'd0);
    step();
    chk("midrst_err", {63'b0, addrErr}, 64'd0);
    chk("midrst_dout1", dataOut1, 64'd0);
    chk("midrst_dout2", dataOut2, 64'd0);
    idle();
    rst = 1'b0;
    #1;
`ifdef MEM_INIT_CLEAR_EN
    // Interrupt the sweep at counter value 50 and confirm a full restart.
    step();
    for (int k = 0; k < 49; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    count_ready_low(n);
    chk("restart_ready_low_cycles", 64'(n), 64'd110);
    en2 = 1; write2 = 0; add2 = 7'd10;
    step();
    chk("restart_addr10_cleared", dataOut2, 64'd0);
`else
    chk("midrst_ready_back", {63'b0, ready}, 64'd1);
    en2 = 1; write2 = 0; add2 = 7'd10;
    step();
    chk("preserved_valid2", {63'b0, valid2}, 64'd1);
    chk("preserved_addr10", dataOut2, PAT);
`endif
    idle();
    step();
    chk("final_valid2_drop", {63'b0, valid2}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule
